// File: rtl/seq_pattern_scheduler.sv
// seq_pattern_scheduler
// Replays a PAT_W-bit pattern MSB-first on `out` for a programmed number of
// repetitions (0 = continuous). The pattern is double-buffered: writes made
// while a run is active land in a shadow register and are promoted only at a
// frame boundary, so a frame is never split between two patterns.
// All outputs are registered, so there is no input-to-output combinational path.

module seq_pattern_scheduler #(
    parameter int               PAT_W    = 8,
    parameter int               CNT_W    = 4,
    parameter logic [PAT_W-1:0] INIT_PAT = 8'b1110_0100
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             start,
    input  logic             stop,
    output logic             out,
    output logic             busy,
    output logic             frame,
    output logic             done
);

    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] act_pat;
    logic [PAT_W-1:0] shd_pat;
    logic             shd_vld;
    logic [CNT_W-1:0] rep_reg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] rep_cnt;

    logic [IDX_W-1:0] idx_dec;
    logic [CNT_W-1:0] rep_nxt;
    logic [PAT_W-1:0] next_frame_pat;
    logic [PAT_W-1:0] start_pat;
    logic             last_rep;

    // Next-bit index, incremented repetition count and the end-of-run test.
    always_comb begin
        idx_dec  = idx - 1'b1;
        rep_nxt  = rep_cnt + 1'b1;
        last_rep = (rep_reg != '0) && (rep_nxt == rep_reg);
    end

    // Pattern that the next frame will use: the shadow wins if one is pending;
    // on a start with a simultaneous load the freshly written pattern is used.
    always_comb begin
        next_frame_pat = shd_vld ? shd_pat : act_pat;
        start_pat      = load ? pat_in : act_pat;
    end

    // Sequencer: state, pattern buffers, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            act_pat <= INIT_PAT;
            shd_pat <= '0;
            shd_vld <= 1'b0;
            rep_reg <= CNT_W'(1);
            idx     <= IDX_TOP;
            rep_cnt <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            frame   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    out   <= 1'b0;
                    busy  <= 1'b0;
                    frame <= 1'b0;
                    // No run in progress, so software writes go straight to
                    // the active registers.
                    if (load) begin
                        act_pat <= pat_in;
                        rep_reg <= rep_in;
                    end
                    if (start && !stop) begin
                        state   <= S_RUN;
                        idx     <= IDX_TOP;
                        rep_cnt <= '0;
                        out     <= start_pat[PAT_W-1];
                        busy    <= 1'b1;
                        frame   <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        // Abort: no done pulse, and a pending shadow is dropped.
                        state   <= S_IDLE;
                        out     <= 1'b0;
                        busy    <= 1'b0;
                        frame   <= 1'b0;
                        shd_vld <= 1'b0;
                    end else begin
                        if (idx == '0) begin
                            // Frame end: promote shadow, count the repetition.
                            if (shd_vld) begin
                                act_pat <= shd_pat;
                                shd_vld <= 1'b0;
                            end
                            rep_cnt <= rep_nxt;
                            if (last_rep) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                out   <= 1'b0;
                                busy  <= 1'b0;
                                frame <= 1'b0;
                            end else begin
                                idx   <= IDX_TOP;
                                out   <= next_frame_pat[PAT_W-1];
                                frame <= 1'b1;
                            end
                        end else begin
                            idx   <= idx_dec;
                            out   <= act_pat[idx_dec];
                            frame <= 1'b0;
                        end
                        // Placed after the promotion so a write on the
                        // frame-end cycle stays pending for the next frame end.
                        if (load) begin
                            shd_pat <= pat_in;
                            shd_vld <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // A write made on the final frame-end cycle is still in the
                    // shadow; the run is over, so it becomes the active pattern.
                    // Writes during this single cycle are not accepted.
                    state <= S_IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                    frame <= 1'b0;
                    if (shd_vld) begin
                        act_pat <= shd_pat;
                        shd_vld <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    out   <= 1'b0;
                    busy  <= 1'b0;
                    frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_pattern_scheduler.md
# seq_pattern_scheduler

Controller that sequences a programmable serial pattern output. It holds a PAT_W-bit pattern and replays it MSB-first on `out` for a programmed number of repetitions, with start, stop and done handshakes. A double-buffered pattern register lets software retarget the pattern mid-run without glitching a frame. It sits between the control registers and the pattern output pin and owns all timing of the serial sequence.

## Interface
- `PAT_W`, 8: pattern length in bits, ≥2.
- `CNT_W`, 4: repetition-count width.
- `INIT_PAT`, 8'b1110_0100: pattern loaded at reset.
- `clk`  in  1  single clock, rising-edge.
- `rstn`  in  1  synchronous, active-low reset.
- `load`  in  1  write `pat_in`/`rep_in` this cycle.
- `pat_in`  in  PAT_W  new pattern.
- `rep_in`  in  CNT_W  repetitions per run; 0 = continuous.
- `start`  in  1  begin a run; level sampled, acted on only in IDLE.
- `stop`  in  1  abort a run.
- `out`  out  1  serial pattern bit.
- `busy`  out  1  high while in RUN.
- `frame`  out  1  high on the cycle `out` carries bit PAT_W-1 of a frame.
- `done`  out  1  one-cycle pulse after the final bit of a finite run.

## Operation
- Registers: `act_pat` (active), `shd_pat` + `shd_vld` (shadow), `rep_reg`, bit index `idx` (counts PAT_W-1 down to 0), repetition counter `rep_cnt` (CNT_W bits).
- Reset (`rstn`=0 at a clock edge): state IDLE, `out`=0, `busy`=0, `frame`=0, `done`=0, `act_pat`=INIT_PAT, `shd_vld`=0, `rep_reg`=1, `idx`=PAT_W-1, `rep_cnt`=0.
- States:
  - IDLE: `out`=0, `busy`=0. `load` writes `act_pat` and `rep_reg` directly. If `start`=1 and `stop`=0, go to RUN with `idx`=PAT_W-1 and `rep_cnt`=0.
  - RUN: `out`=`act_pat[idx]`, `busy`=1, `frame`=(`idx`==PAT_W-1). `idx` decrements each cycle. At `idx`==0 it wraps to PAT_W-1. That cycle is the frame end.
  - At frame end: if `shd_vld`, copy `shd_pat` to `act_pat` and clear `shd_vld`. Increment `rep_cnt`. If `rep_reg`≠0 and the incremented `rep_cnt` equals `rep_reg`, go to DONE. Otherwise stay in RUN.
  - DONE: one cycle. `done`=1, `busy`=0, `out`=0. Then go to IDLE.
- `load` during RUN writes `shd_pat` and sets `shd_vld`; a later load overwrites it. `rep_in` is ignored during RUN. `rep_reg` changes only in IDLE.
- `stop` in RUN: next cycle IDLE, `out`=0, `busy`=0, no `done` pulse, pending shadow discarded (`shd_vld`=0).
- `start` in RUN or DONE is ignored. `stop` in IDLE or DONE is ignored.
- Simultaneous events:
  - `start`+`stop` in IDLE: remain IDLE.
  - `load`+`start` in IDLE: the new pattern and count are used for the run.
  - `load` on a frame-end cycle in RUN: the write lands in the shadow and is applied at the following frame end.
  - `stop` on the final bit: the stop wins and no `done` pulse is issued.
- `rep_reg`=0: continuous run. `rep_cnt` wraps modulo 2^CNT_W, `done` never asserts, only `stop` or reset ends the run.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- `start` sampled high in IDLE at edge T: `out`=bit PAT_W-1 and `busy`=`frame`=1 from T+1. Latency is 1 cycle.
- Bit k of repetition r (0-based, k counted from the MSB) appears at T+1+r·PAT_W+k.
- A finite run of R repetitions: last bit at T+R·PAT_W, `done`=1 at T+R·PAT_W+1, IDLE at T+R·PAT_W+2. The earliest restart is a `start` sampled at T+R·PAT_W+2.
- There is no idle gap between repetitions.
- `stop` sampled at edge S during RUN: `out`=0 and `busy`=0 from S+1.
- Reset mid-run: outputs reach their reset values on the cycle after the reset edge. `act_pat` returns to INIT_PAT.

## Test plan
- Reset, `start` pulse with defaults (rep=1) → `out`=1,1,1,0,0,1,0,0 on cycles 1–8, `frame` on cycle 1 only, `done`=1 on cycle 9, `busy` low from cycle 9.
- `load` pat=8'hA5, rep=2 in IDLE, then `start` → 16 bits 10100101×2, `frame` on cycles 1 and 9, single `done` on cycle 17.
- rep=0, pat=8'hF0, run 40 cycles → 11110000 repeated, `frame` every 8 cycles, no `done`. Then `stop` → `out`=0 and `busy`=0 next cycle, no `done`.
- During a rep=3 run of 8'hFF, `load` 8'h0F at bit index 3 of frame 0 → frame 0 stays all ones, frames 1–2 are 00001111, `done` after frame 2.
- `start`+`stop` together in IDLE → no activity. `stop` on the last bit of a rep=1 run → no `done` pulse.
- Assert `rstn`=0 for one cycle mid-frame after loading 8'h3C → all outputs 0 the next cycle. A new `start` then replays INIT_PAT 11100100.
